// File: rtl/uart_cmd_ctrl.sv
// UART command-frame decoder: header/cmd/arg framing, inter-byte timeout, link watchdog, error count.
// Define UART_CMD_CHECKSUM_EN for the 4-byte frame (HDR, cmd, arg, cmd^arg); default is 3-byte (HDR, cmd, arg).
module uart_cmd_ctrl #(
    parameter logic [7:0]  HDR     = 8'hAA,
    parameter int unsigned BYTE_TO = 20000,
    parameter int unsigned LINK_TO = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_dataerr,
    input  logic       rx_frameerr,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       link_ok,
    output logic       stop,
    output logic [7:0] err_cnt
);
    localparam int unsigned   BW       = $clog2(BYTE_TO + 1);
    localparam int unsigned   LW       = $clog2(LINK_TO + 1);
    localparam logic [BW-1:0] BYTE_MAX = BW'(BYTE_TO);
    localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TO);

    typedef enum logic [1:0] {IDLE, CMD, ARG, CHK} state_t;

    state_t        state_q;
    logic          rx_valid_q, rx_valid_qq;
    logic [7:0]    pend_cmd_q;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    pend_arg_q;
`endif
    logic          cmd_valid_q;
    logic [7:0]    cmd_code_q, cmd_arg_q;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] link_cnt_q, link_cnt_d;
    logic          got_frame_q;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic commit, rx_bad, in_frame, timeout, good_frame, chk_fail, frame_err;

    // A byte is committed in the first cycle the registered rx_valid is low after being high.
    assign commit   = rx_valid_qq & ~rx_valid_q;
    assign rx_bad   = rx_dataerr | rx_frameerr;
    assign in_frame = (state_q != IDLE);
    assign timeout  = in_frame && (byte_cnt_q == BYTE_MAX) && !commit;

`ifdef UART_CMD_CHECKSUM_EN
    assign good_frame = commit && !rx_bad && (state_q == CHK) &&
                        (rx_data == (pend_cmd_q ^ pend_arg_q));
    assign chk_fail   = commit && (state_q == CHK) && !good_frame;
`else
    assign good_frame = commit && !rx_bad && (state_q == ARG);
    assign chk_fail   = 1'b0;
`endif
    assign frame_err = timeout || (commit && in_frame && rx_bad) || chk_fail;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_cnt_d = byte_cnt_q;
        link_cnt_d = link_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (commit || !in_frame || timeout) byte_cnt_d = '0;
        else if (byte_cnt_q != BYTE_MAX)    byte_cnt_d = byte_cnt_q + 1'b1;
        if (cmd_valid_q)                    link_cnt_d = '0;
        else if (link_cnt_q != LINK_MAX)    link_cnt_d = link_cnt_q + 1'b1;
        if (frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            rx_valid_qq <= 1'b0;
            pend_cmd_q  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            pend_arg_q  <= '0;
`endif
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_arg_q   <= '0;
            byte_cnt_q  <= '0;
            link_cnt_q  <= '0;
            got_frame_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            rx_valid_qq <= rx_valid_q;
            byte_cnt_q  <= byte_cnt_d;
            link_cnt_q  <= link_cnt_d;
            err_cnt_q   <= err_cnt_d;
            got_frame_q <= got_frame_q | cmd_valid_q;
            cmd_valid_q <= good_frame;
            if (good_frame) begin
                cmd_code_q <= pend_cmd_q;
`ifdef UART_CMD_CHECKSUM_EN
                cmd_arg_q  <= pend_arg_q;
`else
                cmd_arg_q  <= rx_data;
`endif
            end
            if (timeout) begin
                state_q <= IDLE;
            end else if (commit) begin
                unique case (state_q)
                    IDLE: if (!rx_bad && rx_data == HDR) state_q <= CMD;
                    CMD: begin
                        pend_cmd_q <= rx_data;
                        state_q    <= rx_bad ? IDLE : ARG;
                    end
                    ARG: begin
`ifdef UART_CMD_CHECKSUM_EN
                        pend_arg_q <= rx_data;
                        state_q    <= rx_bad ? IDLE : CHK;
`else
                        state_q    <= IDLE;
`endif
                    end
                    CHK:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign err_cnt   = err_cnt_q;
    assign link_ok   = got_frame_q && (link_cnt_q < LINK_MAX);
    assign stop      = ~link_ok;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a table of byte sequences plus hand-written latency/timeout/link/reset sequences.
// Expectations follow the build: UART_CMD_CHECKSUM_EN selects the 4-byte frame.
module tb_uart_cmd_ctrl;
    localparam int BYTE_TO = 100;
    localparam int LINK_TO = 300;
    localparam int LO      = 3;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid, rx_dataerr, rx_frameerr;
    logic       cmd_valid, link_ok, stop;
    logic [7:0] cmd_code, cmd_arg, err_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pulse_cnt = 0;
    int         p0;
    logic [7:0] exp_err;
    logic [7:0] last_b;

    typedef struct {
        int              n;
        logic [4:0][7:0] b;
        logic [4:0]      de;
        logic [4:0]      fe;
        int              pulses;
        int              code;
        int              arg;
        int              err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    uart_cmd_ctrl #(.HDR(8'hAA), .BYTE_TO(BYTE_TO), .LINK_TO(LINK_TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_dataerr(rx_dataerr), .rx_frameerr(rx_frameerr), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .link_ok(link_ok), .stop(stop),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_valid) pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic de, input logic fe,
                             input int hi = 4, input int lo = LO);
        rx_data     = d;
        rx_dataerr  = de;
        rx_frameerr = fe;
        rx_valid    = 1'b1;
        repeat (hi) tick();
        rx_valid = 1'b0;
        repeat (lo) tick();
        rx_dataerr  = 1'b0;
        rx_frameerr = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] c, input logic [7:0] a, input int hi = 4);
        send_byte(8'hAA, 1'b0, 1'b0, hi);
        send_byte(c, 1'b0, 1'b0, hi);
        send_byte(a, 1'b0, 1'b0, hi);
        if (CHK_EN) send_byte(c ^ a, 1'b0, 1'b0, hi);
    endtask

    function automatic vec_t mkv(input int n, input logic [7:0] b0, b1, b2, b3, b4,
                                 input logic [4:0] de, input logic [4:0] fe,
                                 input int pulses, input int code, input int arg, input int err);
        vec_t v;
        v.n = n;
        v.b = {b4, b3, b2, b1, b0};
        v.de = de;
        v.fe = fe;
        v.pulses = pulses;
        v.code = code;
        v.arg = arg;
        v.err = err;
        return v;
    endfunction

    initial begin
        // Cumulative: each row's expected outputs include every earlier row.
        vecs[0] = mkv(4, 8'hAA, 8'h12, 8'h34, 8'h26, 8'h00, 5'b00000, 5'b00000, 1, 'h12, 'h34, 0);
        vecs[1] = mkv(4, 8'hAA, 8'h56, 8'h78, 8'h00, 8'h00, 5'b00000, 5'b00000,
                      CHK_EN ? 0 : 1, CHK_EN ? 'h12 : 'h56, CHK_EN ? 'h34 : 'h78, CHK_EN ? 1 : 0);
        vecs[2] = mkv(2, 8'hAA, 8'h12, 8'h00, 8'h00, 8'h00, 5'b00000, 5'b00010,
                      0, CHK_EN ? 'h12 : 'h56, CHK_EN ? 'h34 : 'h78, CHK_EN ? 2 : 1);
        vecs[3] = mkv(4, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 5'b00000, 5'b00000,
                      1, 'h01, 'h02, CHK_EN ? 2 : 1);
        vecs[4] = mkv(1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00001, 5'b00000,
                      0, 'h01, 'h02, CHK_EN ? 2 : 1);
        vecs[5] = mkv(4, 8'hAA, 8'hAB, 8'hCD, 8'h66, 8'h00, 5'b00000, 5'b00000,
                      1, 'hAB, 'hCD, CHK_EN ? 2 : 1);
        vecs[6] = mkv(4, 8'hAA, 8'h33, 8'h44, 8'h77, 8'h00, 5'b00100, 5'b00000,
                      0, 'hAB, 'hCD, CHK_EN ? 3 : 2);
        vecs[7] = mkv(5, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'hFF, 5'b00000, 5'b00000,
                      1, 'h0F, 'hF0, CHK_EN ? 3 : 2);
        vecs[8] = mkv(4, 8'hAA, 8'hAA, 8'h10, 8'hBA, 8'h00, 5'b00000, 5'b00000,
                      1, 'hAA, 'h10, CHK_EN ? 3 : 2);
        vecs[9] = mkv(4, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 5'b00000, 5'b01000,
                      CHK_EN ? 0 : 1, CHK_EN ? 'hAA : 'h01, CHK_EN ? 'h10 : 'h02, CHK_EN ? 4 : 2);

        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        rx_dataerr = 1'b0;
        rx_frameerr = 1'b0;
        repeat (2) tick();
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_code", 32'(cmd_code), 0);
        check("rst_cmd_arg", 32'(cmd_arg), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_link_ok", 32'(link_ok), 0);
        check("rst_stop", 32'(stop), 1);
        rst_n = 1'b1;
        repeat (20) tick();
        check("prelink_link_ok", 32'(link_ok), 0);
        check("prelink_stop", 32'(stop), 1);

        for (int i = 0; i < NV; i++) begin
            p0 = pulse_cnt;
            for (int j = 0; j < vecs[i].n; j++)
                send_byte(vecs[i].b[j[2:0]], vecs[i].de[j[2:0]], vecs[i].fe[j[2:0]]);
            repeat (2) tick();
            check($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].pulses);
            check($sformatf("v%0d_code", i), 32'(cmd_code), vecs[i].code);
            check($sformatf("v%0d_arg", i), 32'(cmd_arg), vecs[i].arg);
            check($sformatf("v%0d_err", i), 32'(err_cnt), vecs[i].err);
            check($sformatf("v%0d_link", i), 32'(link_ok), 1);
            check($sformatf("v%0d_stop", i), 32'(stop), 0);
        end
        exp_err = 8'(vecs[NV-1].err);

        // Latency: pulse is high exactly on the second edge after rx_valid falls.
        p0 = pulse_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h21, 1'b0, 1'b0);
        if (CHK_EN) send_byte(8'h43, 1'b0, 1'b0);
        last_b = CHK_EN ? 8'h62 : 8'h43;
        rx_data = last_b;
        rx_valid = 1'b1;
        repeat (4) tick();
        rx_valid = 1'b0;
        tick();
        check("lat_edge1", 32'(cmd_valid), 0);
        tick();
        check("lat_edge2", 32'(cmd_valid), 1);
        tick();
        check("lat_edge3", 32'(cmd_valid), 0);
        check("lat_pulses", pulse_cnt - p0, 1);
        check("lat_code", 32'(cmd_code), 'h21);
        check("lat_arg", 32'(cmd_arg), 'h43);

        // Inter-byte timeout aborts the frame, then a fresh frame decodes.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        repeat (BYTE_TO + 5) tick();
        exp_err = exp_err + 8'd1;
        check("to_err", 32'(err_cnt), 32'(exp_err));
        p0 = pulse_cnt;
        send_good(8'h05, 8'h06);
        check("to_pulses", pulse_cnt - p0, 1);
        check("to_code", 32'(cmd_code), 'h05);
        check("to_arg", 32'(cmd_arg), 'h06);
        check("to_err_hold", 32'(err_cnt), 32'(exp_err));

        // Commit on the exact timeout cycle survives; one cycle later it is aborted.
        p0 = pulse_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0, BYTE_TO + 1 - LO);
        send_byte(8'h3C, 1'b0, 1'b0);
        if (CHK_EN) send_byte(8'h66, 1'b0, 1'b0);
        repeat (2) tick();
        check("race_err", 32'(err_cnt), 32'(exp_err));
        check("race_pulses", pulse_cnt - p0, 1);
        check("race_code", 32'(cmd_code), 'h5A);
        p0 = pulse_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, BYTE_TO + 2 - LO);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        repeat (2) tick();
        exp_err = exp_err + 8'd1;
        check("late_err", 32'(err_cnt), 32'(exp_err));
        check("late_pulses", pulse_cnt - p0, 0);
        check("late_code", 32'(cmd_code), 'h5A);

        // Link watchdog: holds until LINK_TO cycles pass, recovers on the next good frame.
        send_good(8'h77, 8'h88);
        repeat (LINK_TO - 10) tick();
        check("link_before_to", 32'(link_ok), 1);
        check("stop_before_to", 32'(stop), 0);
        repeat (15) tick();
        check("link_after_to", 32'(link_ok), 0);
        check("stop_after_to", 32'(stop), 1);
        send_good(8'h99, 8'h01);
        check("link_restored", 32'(link_ok), 1);
        check("stop_restored", 32'(stop), 0);
        check("link_code", 32'(cmd_code), 'h99);

        // Reset mid-frame with long rx_valid pulses: partial frame vanishes.
        p0 = pulse_cnt;
        send_byte(8'hAA, 1'b0, 1'b0, 50);
        send_byte(8'h12, 1'b0, 1'b0, 50);
        rst_n = 1'b0;
        tick();
        check("mid_rst_code", 32'(cmd_code), 0);
        check("mid_rst_err", 32'(err_cnt), 0);
        check("mid_rst_link", 32'(link_ok), 0);
        check("mid_rst_stop", 32'(stop), 1);
        tick();
        rst_n = 1'b1;
        send_byte(8'h34, 1'b0, 1'b0, 50);
        send_byte(8'h26, 1'b0, 1'b0, 50);
        repeat (2) tick();
        check("post_rst_pulses", pulse_cnt - p0, 0);
        check("post_rst_err", 32'(err_cnt), 0);
        check("post_rst_link", 32'(link_ok), 0);
        send_good(8'h7E, 8'h81, 50);
        check("post_rst_good_pulses", pulse_cnt - p0, 1);
        check("post_rst_good_code", 32'(cmd_code), 'h7E);
        check("post_rst_good_arg", 32'(cmd_arg), 'h81);

        // err_cnt counts to FF and saturates there.
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hAA, 1'b0, 1'b0);
            send_byte(8'h01, 1'b0, 1'b1);
        end
        check("err_254", 32'(err_cnt), 'hFE);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hAA, 1'b0, 1'b0);
            send_byte(8'h01, 1'b0, 1'b1);
        end
        check("err_sat", 32'(err_cnt), 'hFF);
        check("err_sat_code", 32'(cmd_code), 'h7E);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
